// File: rtl/blink_pkg.sv
// Shared constants and helpers for the LED blinker.
// Provides the half-period divide and the counter width derived from it.
// No ports; imported by blink_tick and led_blink.
package blink_pkg;

  // Number of clock cycles per LED half-period (truncating division).
  // Returns 0 for an illegal rate so the top-level check can report it
  // instead of elaboration tripping over a divide by zero.
  function automatic int half_period(input int clk_hz, input int blink_hz);
    if (blink_hz <= 0) begin
      return 0;
    end
    return clk_hz / (2 * blink_hz);
  endfunction

  // Counter width for a given half-period, never narrower than one bit.
  function automatic int cnt_width(input int half);
    int w;
    w = $clog2(half);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/blink_tick.sv
// Half-period tick generator: free-running counter that wraps at HALF-1.
// Ports: clk (board clock), rst_n (sync active-low reset), tick (combinational,
//        high for the one cycle in which the counter sits at HALF-1).
module blink_tick
  import blink_pkg::*;
#(
  parameter int HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = cnt_width(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // With HALF == 1 the counter stays at 0 and the tick is high every cycle.
  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink.sv
// Free-running LED blinker: 50 % duty square wave at BLINK_HZ from CLK_HZ.
// Ports: clk (board clock), rst_n (sync active-low reset), led (registered
//        drive, inverted when LED_ACTIVE_LOW is set).
module led_blink
  import blink_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int BLINK_HZ       = 1,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  output logic led
);

  localparam int HALF = half_period(CLK_HZ, BLINK_HZ);
  // Keeps the sub-module well-formed while the error below is reported.
  localparam int HALF_SAFE = (HALF < 1) ? 1 : HALF;

  generate
    if (BLINK_HZ == 0) begin : g_err_zero_rate
      $error("led_blink: BLINK_HZ must be non-zero");
    end else if (CLK_HZ < 2 * BLINK_HZ) begin : g_err_too_fast
      $error("led_blink: CLK_HZ must be at least 2*BLINK_HZ");
    end
  endgenerate

  logic tick;
  logic state_q;
  logic state_d;
  logic led_q;

  blink_tick #(
    .HALF (HALF_SAFE)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    if (tick) begin
      state_d = ~state_q;
    end
  end

  // The polarity XOR is folded in before the register so the pin is driven
  // straight from a flop and toggles on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= 1'b0;
      led_q   <= LED_ACTIVE_LOW;
    end else begin
      state_q <= state_d;
      led_q   <= state_d ^ LED_ACTIVE_LOW;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_blink.sv
module tb_led_blink;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a = 1'b0;   // HALF=5, active high
  logic rst_b = 1'b0;   // HALF=1
  logic rst_c = 1'b0;   // HALF=5, active low
  logic rst_d = 1'b0;   // defaults
  logic led_a, led_b, led_c, led_d;

  int total = 0;
  int bad   = 0;
  logic exp_q[$];

  led_blink #(.CLK_HZ(1000), .BLINK_HZ(100), .LED_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_a), .led(led_a));
  led_blink #(.CLK_HZ(2), .BLINK_HZ(1), .LED_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_b), .led(led_b));
  led_blink #(.CLK_HZ(1000), .BLINK_HZ(100), .LED_ACTIVE_LOW(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_c), .led(led_c));
  led_blink dut_d (
    .clk(clk), .rst_n(rst_d), .led(led_d));

  // Expected LED level after active edge k (k>=1) for a given half-period.
  function automatic logic model_led(input int k, input int half, input logic pol);
    return logic'((k / half) % 2) ^ pol;
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick_edge();
      total++;
      if (led_a !== 1'b0) begin
        bad++;
        $display("FAIL reset_led_a cycle=%0d got=%b want=0", i, led_a);
      end
      total++;
      if (dut_a.u_tick.cnt_q !== 3'd0) begin
        bad++;
        $display("FAIL reset_cnt_a cycle=%0d got=%0d want=0", i, dut_a.u_tick.cnt_q);
      end
      total++;
      if (led_c !== 1'b1) begin
        bad++;
        $display("FAIL reset_led_c cycle=%0d got=%b want=1", i, led_c);
      end
    end
  endtask

  task automatic test_basic_toggle();
    logic e;
    rst_a = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      exp_q.push_back(model_led(k, 5, 1'b0));
      tick_edge();
      e = exp_q.pop_front();
      total++;
      if (led_a !== e) begin
        bad++;
        $display("FAIL basic_toggle edge=%0d got=%b want=%b", k, led_a, e);
      end
    end
  endtask

  task automatic test_min_divide();
    logic e;
    rst_b = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back(model_led(k, 1, 1'b0));
      tick_edge();
      e = exp_q.pop_front();
      total++;
      if (led_b !== e) begin
        bad++;
        $display("FAIL min_divide edge=%0d got=%b want=%b", k, led_b, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic e;
    rst_a = 1'b0;
    tick_edge();
    rst_a = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(model_led(k, 5, 1'b0));
      tick_edge();
      e = exp_q.pop_front();
      total++;
      if (led_a !== e) begin
        bad++;
        $display("FAIL mid_reset_pre edge=%0d got=%b want=%b", k, led_a, e);
      end
    end
    // Edge 7 samples reset while the LED is high.
    rst_a = 1'b0;
    tick_edge();
    total++;
    if (led_a !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_clear_led got=%b want=0", led_a);
    end
    total++;
    if (dut_a.u_tick.cnt_q !== 3'd0) begin
      bad++;
      $display("FAIL mid_reset_clear_cnt got=%0d want=0", dut_a.u_tick.cnt_q);
    end
    rst_a = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      exp_q.push_back(model_led(k, 5, 1'b0));
      tick_edge();
      e = exp_q.pop_front();
      total++;
      if (led_a !== e) begin
        bad++;
        $display("FAIL mid_reset_post edge=%0d got=%b want=%b", k, led_a, e);
      end
    end
  endtask

  task automatic test_polarity();
    logic e;
    rst_c = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      exp_q.push_back(model_led(k, 5, 1'b1));
      tick_edge();
      e = exp_q.pop_front();
      total++;
      if (led_c !== e) begin
        bad++;
        $display("FAIL polarity edge=%0d got=%b want=%b", k, led_c, e);
      end
    end
  endtask

  task automatic test_defaults();
    logic e;
    total++;
    if (led_d !== 1'b0) begin
      bad++;
      $display("FAIL defaults_reset got=%b want=0", led_d);
    end
    rst_d = 1'b1;
    for (int k = 1; k <= 5000; k++) begin
      exp_q.push_back(model_led(k, 25_000_000, 1'b0));
      tick_edge();
      e = exp_q.pop_front();
      total++;
      if (led_d !== e) begin
        bad++;
        $display("FAIL defaults_led edge=%0d got=%b want=%b", k, led_d, e);
      end
    end
    total++;
    if (dut_d.u_tick.cnt_q !== 25'd5000) begin
      bad++;
      $display("FAIL defaults_cnt got=%0d want=5000", dut_d.u_tick.cnt_q);
    end
  endtask

  initial begin
    test_reset();
    test_basic_toggle();
    test_min_divide();
    test_mid_reset();
    test_polarity();
    test_defaults();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
